pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Control FSM that owns the program counter register's write-enable (contro) and data input (datain).
- Sequences fetch/execute for the multicycle core: PC+4 on fetch acknowledge, then redirects for branch, jump, jump-register, traps.
- Fetch handshake carries a watchdog; timeout, external exception and misaligned jump-register vector to EXC_VECTOR and write EPC.
- Sits between control unit, ALU/branch logic and the PC register.

Parameters:
WIDTH, 32, PC/address width
RESET_VECTOR, 32'h0000_0000, first fetch address after reset
EXC_VECTOR, 32'h0000_0080, trap handler address
FETCH_TIMEOUT, 8, max cycles in FETCH without fetch_ack before trap (>=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
pc_in  in  WIDTH  current PC register output (dataout)
fetch_ack  in  1  memory accepted/returned instruction
instr_done  in  1  datapath finished sequential instruction
br_req  in  1  conditional branch resolved this cycle
br_ne  in  1  1=bne semantics, 0=beq
br_zero  in  1  ALU zero flag
br_target  in  WIDTH  branch target
jmp_req  in  1  j/jal
jmp_index  in  26  instruction index field
jr_req  in  1  jump register
jr_addr  in  WIDTH  register jump address
exc_req  in  1  external/datapath exception
pc_next  out  WIDTH  to PC datain
pc_write  out  1  to PC contro
fetch_req  out  1  fetch request to memory
epc_write  out  1  EPC load strobe
epc_value  out  WIDTH  EPC data
exc_cause  out  2  00 none, 01 exc_req, 10 fetch timeout, 11 misaligned jr
state_o  out  2  current state, debug

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- State encodings: IDLE=0, FETCH=1, EXEC=2, TRAP=3.
- Reset:
  - state=IDLE, watchdog=0, exc_cause=00, epc latch=0.
  - All strobes 0 during the reset cycle; applies from any state, including mid-fetch.
- Output timing: pc_write, pc_next, fetch_req, epc_write are combinational from state and inputs. PC loads at the edge ending the cycle in which pc_write=1.
- IDLE: pc_write=1, pc_next=RESET_VECTOR; go to FETCH.
- FETCH: fetch_req=1.
  - fetch_ack=1: pc_write=1, pc_next=pc_in+4 (mod 2^WIDTH); go to EXEC; watchdog cleared.
  - Else watchdog+1. At watchdog==FETCH_TIMEOUT-1 with no ack: latch epc=pc_in, cause=10; go to TRAP.
  - Ack on the final watchdog cycle wins over timeout.
  - exc_req and redirect inputs are ignored in FETCH.
- EXEC: one event per cycle, priority exc_req > jr_req > jmp_req > br_req > instr_done.
  - exc_req: latch epc=pc_in-4, cause=01; go to TRAP; pc_write=0.
  - jr_req with jr_addr[1:0]!=0: latch epc=pc_in-4, cause=11; go to TRAP.
  - jr_req, aligned: pc_write=1, pc_next=jr_addr; go to FETCH.
  - jmp_req: pc_write=1, pc_next={pc_in[31:28], jmp_index, 2'b00}; go to FETCH.
  - br_req: taken = br_ne ? ~br_zero : br_zero.
    - Taken: pc_write=1, pc_next=br_target.
    - Not taken: pc_write=0.
    - Either way, go to FETCH.
  - instr_done: pc_write=0; go to FETCH.
  - No event: stay in EXEC; pc_write=0 (PC holds).
- TRAP (one cycle): epc_write=1, epc_value=latched epc, pc_write=1, pc_next=EXC_VECTOR; go to FETCH. All inputs ignored.
- exc_cause is registered, updated only on trap entry, and held until the next trap or reset.
- epc_value always shows the latch.
- pc_next defaults to pc_in whenever pc_write=0.

Decomposition:
- Shared package pc_seq_pkg: state encodings, cause codes (CAUSE_NONE/EXT/TIMEOUT/MISALIGN), default vectors.
- Sub-module fetch_watchdog: counter with clear/enable and timeout flag, sized by FETCH_TIMEOUT.
- Next-PC mux stays inline.

Test Plan:
- Reset for 5 cycles, then release → IDLE writes 0: pc_write=1, pc_next=0; next cycle state FETCH, fetch_req=1.
- pc_in=0, fetch_ack after 2 cycles → pc_next=4 with pc_write=1 in the ack cycle; then instr_done → FETCH, PC stays 4.
- Branch cases, PC=8 in EXEC:
  - br_req, br_ne=0, br_zero=1, br_target=7 → pc_write=1, pc_next=7.
  - Same with br_zero=0 → pc_write=0, back to FETCH.
- Jump cases:
  - pc_in=32'h1000_0008, jmp_index=26'h8 → pc_next=32'h1000_0020.
  - jr_addr=32'h0000_0007 → TRAP, then epc_write=1, epc_value=32'h1000_0004, exc_cause=11, pc_next=32'h80.
- Fetch timeout: hold fetch_ack=0 with pc_in=8 → after 8 FETCH cycles, TRAP; epc_value=8, exc_cause=10.
- Priority and reset:
  - exc_req, jmp_req and br_req together in EXEC → TRAP with cause=01, no PC write in that cycle.
  - Assert reset while in TRAP → next state IDLE, exc_cause=00, epc_write=0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_TRAP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_EXT      = 2'b01,
    CAUSE_TIMEOUT  = 2'b10,
    CAUSE_MISALIGN = 2'b11
  } cause_t;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;
  localparam int unsigned DEF_FETCH_TIMEOUT = 8;

endpackage

// File: rtl/pc_sequencer_fetch_watchdog.sv
// Fetch watchdog: counts un-acknowledged FETCH cycles, flags the last allowed one.
module fetch_watchdog #(
  parameter int unsigned FETCH_TIMEOUT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_timeout
);

  localparam int unsigned CW = (FETCH_TIMEOUT > 2) ? $clog2(FETCH_TIMEOUT) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_timeout = i_enable && (r_cnt == CW'(FETCH_TIMEOUT - 1));

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer driving the PC register write-enable and data input,
// including trap entry with EPC capture.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned       WIDTH         = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR  = DEF_RESET_VECTOR,
  parameter logic [WIDTH-1:0]  EXC_VECTOR    = DEF_EXC_VECTOR,
  parameter int unsigned       FETCH_TIMEOUT = DEF_FETCH_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             fetch_ack,
  input  logic             instr_done,
  input  logic             br_req,
  input  logic             br_ne,
  input  logic             br_zero,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp_req,
  input  logic [25:0]      jmp_index,
  input  logic             jr_req,
  input  logic [WIDTH-1:0] jr_addr,
  input  logic             exc_req,
  output logic [WIDTH-1:0] pc_next,
  output logic             pc_write,
  output logic             fetch_req,
  output logic             epc_write,
  output logic [WIDTH-1:0] epc_value,
  output logic [1:0]       exc_cause,
  output logic [1:0]       state_o
);

  state_t           r_state, w_state_nxt;
  cause_t           r_cause, w_cause_nxt;
  logic [WIDTH-1:0] r_epc, w_epc_nxt;
  logic             w_trap;
  logic             w_wd_clear, w_wd_en, w_wd_timeout;
  logic             w_br_taken;
  logic [WIDTH-1:0] w_jmp_tgt;

  fetch_watchdog #(.FETCH_TIMEOUT(FETCH_TIMEOUT)) u_wd (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_wd_clear),
    .i_enable  (w_wd_en),
    .o_timeout (w_wd_timeout)
  );

  // Watchdog only runs across consecutive un-acked FETCH cycles.
  assign w_wd_en    = (r_state == S_FETCH);
  assign w_wd_clear = (r_state != S_FETCH) || fetch_ack || w_wd_timeout;

  assign w_br_taken = br_ne ? ~br_zero : br_zero;

  always_comb begin
    w_jmp_tgt       = pc_in;
    w_jmp_tgt[27:0] = {jmp_index, 2'b00};
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
    w_epc_nxt   = r_epc;
    w_trap      = 1'b0;
    pc_write    = 1'b0;
    pc_next     = pc_in;
    fetch_req   = 1'b0;
    epc_write   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        pc_write    = 1'b1;
        pc_next     = RESET_VECTOR;
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        fetch_req = 1'b1;
        if (fetch_ack) begin
          pc_write    = 1'b1;
          pc_next     = pc_in + WIDTH'(4);
          w_state_nxt = S_EXEC;
        end else if (w_wd_timeout) begin
          w_trap      = 1'b1;
          w_epc_nxt   = pc_in;
          w_cause_nxt = CAUSE_TIMEOUT;
          w_state_nxt = S_TRAP;
        end
      end
      S_EXEC: begin
        if (exc_req) begin
          w_trap      = 1'b1;
          w_epc_nxt   = pc_in - WIDTH'(4);
          w_cause_nxt = CAUSE_EXT;
          w_state_nxt = S_TRAP;
        end else if (jr_req) begin
          if (|jr_addr[1:0]) begin
            w_trap      = 1'b1;
            w_epc_nxt   = pc_in - WIDTH'(4);
            w_cause_nxt = CAUSE_MISALIGN;
            w_state_nxt = S_TRAP;
          end else begin
            pc_write    = 1'b1;
            pc_next     = jr_addr;
            w_state_nxt = S_FETCH;
          end
        end else if (jmp_req) begin
          pc_write    = 1'b1;
          pc_next     = w_jmp_tgt;
          w_state_nxt = S_FETCH;
        end else if (br_req) begin
          pc_write    = w_br_taken;
          pc_next     = w_br_taken ? br_target : pc_in;
          w_state_nxt = S_FETCH;
        end else if (instr_done) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_TRAP: begin
        epc_write   = 1'b1;
        pc_write    = 1'b1;
        pc_next     = EXC_VECTOR;
        w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (reset) begin
      pc_write  = 1'b0;
      pc_next   = pc_in;
      fetch_req = 1'b0;
      epc_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cause <= CAUSE_NONE;
      r_epc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_trap) begin
        r_cause <= w_cause_nxt;
        r_epc   <= w_epc_nxt;
      end
    end
  end

  assign epc_value = r_epc;
  assign exc_cause = r_cause;
  assign state_o   = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer.
module tb_pc_sequencer;

  localparam int SIG_PCW   = 0;
  localparam int SIG_PCN   = 1;
  localparam int SIG_FREQ  = 2;
  localparam int SIG_EPCW  = 3;
  localparam int SIG_EPCV  = 4;
  localparam int SIG_CAUSE = 5;
  localparam int SIG_STATE = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        fetch_ack, instr_done, br_req, br_ne, br_zero;
  logic [31:0] br_target;
  logic        jmp_req;
  logic [25:0] jmp_index;
  logic        jr_req;
  logic [31:0] jr_addr;
  logic        exc_req;
  logic [31:0] pc_next;
  logic        pc_write, fetch_req, epc_write;
  logic [31:0] epc_value;
  logic [1:0]  exc_cause;
  logic [1:0]  state_o;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .WIDTH         (32),
    .RESET_VECTOR  (32'h0000_0000),
    .EXC_VECTOR    (32'h0000_0080),
    .FETCH_TIMEOUT (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_in      (pc_in),
    .fetch_ack  (fetch_ack),
    .instr_done (instr_done),
    .br_req     (br_req),
    .br_ne      (br_ne),
    .br_zero    (br_zero),
    .br_target  (br_target),
    .jmp_req    (jmp_req),
    .jmp_index  (jmp_index),
    .jr_req     (jr_req),
    .jr_addr    (jr_addr),
    .exc_req    (exc_req),
    .pc_next    (pc_next),
    .pc_write   (pc_write),
    .fetch_req  (fetch_req),
    .epc_write  (epc_write),
    .epc_value  (epc_value),
    .exc_cause  (exc_cause),
    .state_o    (state_o)
  );

  function automatic logic [31:0] observed(int sig);
    case (sig)
      SIG_PCW:   return {31'b0, pc_write};
      SIG_PCN:   return pc_next;
      SIG_FREQ:  return {31'b0, fetch_req};
      SIG_EPCW:  return {31'b0, epc_write};
      SIG_EPCV:  return epc_value;
      SIG_CAUSE: return {30'b0, exc_cause};
      default:   return {30'b0, state_o};
    endcase
  endfunction

  task automatic want(input int sig, input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle, then retire every queued expectation.
  task automatic check();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      obs = observed(e.sig);
      n_assert++;
      assert (obs === e.val)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    reset = 1'b1; pc_in = '0; fetch_ack = 1'b0; instr_done = 1'b0;
    br_req = 1'b0; br_ne = 1'b0; br_zero = 1'b0; br_target = '0;
    jmp_req = 1'b0; jmp_index = '0; jr_req = 1'b0; jr_addr = '0; exc_req = 1'b0;

    repeat (5) cyc();
    want(SIG_STATE, "rst_state", 0); want(SIG_PCW, "rst_pcw", 0);
    want(SIG_FREQ, "rst_freq", 0);   want(SIG_EPCW, "rst_epcw", 0);
    want(SIG_CAUSE, "rst_cause", 0); want(SIG_EPCV, "rst_epcv", 0);
    check();

    reset = 1'b0;
    want(SIG_PCW, "idle_pcw", 1); want(SIG_PCN, "idle_pcn", 0);
    check();

    cyc();
    want(SIG_STATE, "fetch_state", 1); want(SIG_FREQ, "fetch_req", 1);
    want(SIG_PCW, "fetch_wait_pcw", 0);
    check();
    cyc();
    want(SIG_PCW, "fetch_wait2_pcw", 0);
    check();
    cyc(); fetch_ack = 1'b1;
    want(SIG_PCW, "ack_pcw", 1); want(SIG_PCN, "ack_pcn", 32'h4);
    check();

    cyc(); fetch_ack = 1'b0; pc_in = 32'h4; instr_done = 1'b1;
    want(SIG_STATE, "exec_state", 2); want(SIG_PCW, "done_pcw", 0);
    want(SIG_PCN, "done_pcn", 32'h4);
    check();
    cyc(); instr_done = 1'b0; fetch_ack = 1'b1;
    want(SIG_STATE, "done_to_fetch", 1); want(SIG_PCN, "ack2_pcn", 32'h8);
    check();

    cyc(); fetch_ack = 1'b0; pc_in = 32'h8;
    br_req = 1'b1; br_ne = 1'b0; br_zero = 1'b1; br_target = 32'h7;
    want(SIG_PCW, "beq_taken_pcw", 1); want(SIG_PCN, "beq_taken_pcn", 32'h7);
    check();
    cyc(); br_req = 1'b0; fetch_ack = 1'b1;
    want(SIG_STATE, "br_to_fetch", 1);
    check();
    cyc(); fetch_ack = 1'b0; pc_in = 32'h8; br_req = 1'b1; br_zero = 1'b0;
    want(SIG_PCW, "beq_nt_pcw", 0); want(SIG_PCN, "beq_nt_pcn", 32'h8);
    check();
    cyc(); br_req = 1'b0; fetch_ack = 1'b1; pc_in = 32'h1000_0004;
    want(SIG_STATE, "brnt_to_fetch", 1); want(SIG_PCN, "ack3_pcn", 32'h1000_0008);
    check();

    cyc(); fetch_ack = 1'b0; pc_in = 32'h1000_0008; jmp_req = 1'b1; jmp_index = 26'h8;
    want(SIG_PCW, "jmp_pcw", 1); want(SIG_PCN, "jmp_pcn", 32'h1000_0020);
    check();
    cyc(); jmp_req = 1'b0; fetch_ack = 1'b1; pc_in = 32'h1000_0004;
    want(SIG_STATE, "jmp_to_fetch", 1);
    check();
    cyc(); fetch_ack = 1'b0; pc_in = 32'h1000_0008; jr_req = 1'b1; jr_addr = 32'h7;
    want(SIG_STATE, "jr_exec", 2); want(SIG_PCW, "jr_mis_pcw", 0);
    check();
    cyc(); jr_req = 1'b0;
    want(SIG_STATE, "jr_trap", 3); want(SIG_EPCW, "jr_epcw", 1);
    want(SIG_EPCV, "jr_epcv", 32'h1000_0004); want(SIG_CAUSE, "jr_cause", 3);
    want(SIG_PCW, "trap_pcw", 1); want(SIG_PCN, "trap_pcn", 32'h80);
    check();

    pc_in = 32'h8;
    for (int i = 0; i < 8; i++) begin
      cyc();
      want(SIG_STATE, $sformatf("wd_fetch%0d", i), 1);
      want(SIG_PCW, $sformatf("wd_pcw%0d", i), 0);
      check();
    end
    cyc();
    want(SIG_STATE, "to_trap", 3); want(SIG_EPCV, "to_epcv", 32'h8);
    want(SIG_CAUSE, "to_cause", 2);
    check();

    for (int i = 0; i < 7; i++) begin
      cyc();
      want(SIG_STATE, $sformatf("wd2_fetch%0d", i), 1);
      check();
    end
    cyc(); pc_in = 32'hFFFF_FFFC; fetch_ack = 1'b1;
    want(SIG_STATE, "lastack_state", 1); want(SIG_PCW, "lastack_pcw", 1);
    want(SIG_PCN, "lastack_wrap", 32'h0);
    check();

    cyc(); fetch_ack = 1'b0; pc_in = 32'h20;
    want(SIG_STATE, "lastack_exec", 2); want(SIG_PCW, "noevt_pcw", 0);
    check();
    cyc(); exc_req = 1'b1; jmp_req = 1'b1; br_req = 1'b1; br_zero = 1'b1;
    want(SIG_STATE, "exec_hold", 2); want(SIG_PCW, "prio_pcw", 0);
    want(SIG_PCN, "prio_pcn", 32'h20);
    check();
    cyc(); exc_req = 1'b0; jmp_req = 1'b0; br_req = 1'b0; reset = 1'b1;
    want(SIG_STATE, "prio_trap", 3); want(SIG_CAUSE, "prio_cause", 1);
    want(SIG_EPCV, "prio_epcv", 32'h1C); want(SIG_EPCW, "rsttrap_epcw", 0);
    want(SIG_PCW, "rsttrap_pcw", 0);
    check();
    cyc();
    want(SIG_STATE, "rst2_state", 0); want(SIG_CAUSE, "rst2_cause", 0);
    want(SIG_EPCV, "rst2_epcv", 0); want(SIG_EPCW, "rst2_epcw", 0);
    check();
    reset = 1'b0;
    want(SIG_PCW, "idle2_pcw", 1);
    check();

    cyc(); pc_in = 32'h0; fetch_ack = 1'b1;
    want(SIG_PCN, "ack4_pcn", 32'h4);
    check();
    cyc(); fetch_ack = 1'b0; pc_in = 32'h4; jr_req = 1'b1; jr_addr = 32'h40;
    want(SIG_PCW, "jr_al_pcw", 1); want(SIG_PCN, "jr_al_pcn", 32'h40);
    check();
    cyc(); jr_req = 1'b0; fetch_ack = 1'b1; pc_in = 32'h40;
    want(SIG_STATE, "jr_to_fetch", 1); want(SIG_PCN, "ack5_pcn", 32'h44);
    check();
    cyc(); fetch_ack = 1'b0; pc_in = 32'h44;
    br_req = 1'b1; br_ne = 1'b1; br_zero = 1'b0; br_target = 32'h100;
    want(SIG_PCW, "bne_taken_pcw", 1); want(SIG_PCN, "bne_taken_pcn", 32'h100);
    check();
    cyc(); br_req = 1'b0;
    want(SIG_STATE, "bne_to_fetch", 1);
    check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
